// File: rtl/if_id_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_skid_stage
//  Purpose  : IF/ID pipeline stage with a valid/ready handshake, a two-entry
//             skid buffer, synchronous flush with bubble insertion and a
//             saturating fetch-stall counter. Every output comes from a flop.
//  Revision : 1.0  initial release
// ============================================================================
module if_id_skid_stage #(
   parameter int                DATA_W = 8,
   parameter logic [DATA_W-1:0] BUBBLE = '0,
   parameter int                CNT_W  = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Flush,
   input  logic              In_Valid,
   output logic              In_Ready,
   input  logic [DATA_W-1:0] In_Data,
   output logic              Out_Valid,
   input  logic              Out_Ready,
   output logic [DATA_W-1:0] Out_Data,
   output logic [1:0]        Occupancy,
   output logic [CNT_W-1:0]  Stall_Count,
   input  logic              Stall_Clr
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] main_nxt;
   logic [DATA_W-1:0] skid_q;
   logic [DATA_W-1:0] skid_nxt;
   logic [CNT_W-1:0]  stall_q;
   logic              accept;
   logic              drain;
   logic              stall;

   // Handshake flags are decoded from the state flops only, so Out_Ready
   // never reaches In_Ready combinationally; the skid entry absorbs the
   // payload fetch may still push in the cycle decode stalls.
   assign In_Ready  = (state != FULL);
   assign Out_Valid = (state != EMPTY);
   assign Occupancy = (state == FULL) ? 2'd2 : ((state == ONE) ? 2'd1 : 2'd0);
   assign Out_Data  = main_q;   // main is reloaded with BUBBLE whenever it empties
   assign Stall_Count = stall_q;

   assign accept = In_Valid & In_Ready;
   assign drain  = Out_Valid & Out_Ready;
   assign stall  = In_Valid & ~In_Ready;

   // State and payload registers; reset clears everything without a clock edge.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state  <= EMPTY;
         main_q <= BUBBLE;
         skid_q <= BUBBLE;
      end else begin
         state  <= state_nxt;
         main_q <= main_nxt;
         skid_q <= skid_nxt;
      end
   end

   // Next-state and datapath selection; flush wins over any accept or drain.
   always_comb begin
      state_nxt = state;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
      if (Flush) begin
         state_nxt = EMPTY;
         main_nxt  = BUBBLE;
         skid_nxt  = BUBBLE;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  state_nxt = ONE;
                  main_nxt  = In_Data;
               end
            end
            ONE: begin
               if (accept && drain) begin
                  main_nxt = In_Data;
               end else if (accept) begin
                  state_nxt = FULL;
                  skid_nxt  = In_Data;
               end else if (drain) begin
                  state_nxt = EMPTY;
                  main_nxt  = BUBBLE;
               end
            end
            FULL: begin
               if (drain) begin
                  state_nxt = ONE;
                  main_nxt  = skid_q;
                  skid_nxt  = BUBBLE;
               end
            end
            default: begin
               // Unreachable encoding: recover to a clean empty stage.
               state_nxt = EMPTY;
               main_nxt  = BUBBLE;
               skid_nxt  = BUBBLE;
            end
         endcase
      end
   end

   // Saturating count of cycles where fetch offers a payload but is held off.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         stall_q <= '0;
      end else if (Stall_Clr) begin
         stall_q <= '0;
      end else if (stall && (stall_q != CNT_MAX)) begin
         stall_q <= stall_q + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: doc/if_id_skid_stage.md
# if_id_skid_stage

Parametrised IF/ID pipeline stage with a valid/ready handshake, a two-entry skid buffer, synchronous flush with bubble insertion, and a saturating stall counter. It sits between instruction fetch and decode and carries the instruction code and any sideband fields packed into `In_Data`. Decode back-pressure stalls fetch without a combinational path from `Out_Ready` to `In_Ready`. A branch or jump flush replaces every in-flight instruction with a NOP bubble.

## Interface
Parameters:
- `DATA_W`, default 8: width of the payload (instruction code plus sideband).
- `BUBBLE`, default 0: value driven on `Out_Data` whenever `Out_Valid`=0 (the NOP encoding).
- `CNT_W`, default 8: width of the stall counter.

Ports:
- `Clk`, input, 1: clock. All state changes on the rising edge.
- `Reset`, input, 1: reset, asynchronous, active-low.
- `Flush`, input, 1: synchronous flush; discards all contents.
- `In_Valid`, input, 1: fetch presents a valid payload.
- `In_Ready`, output, 1: stage can accept a payload this cycle.
- `In_Data`, input, `DATA_W`: payload from fetch.
- `Out_Valid`, output, 1: `Out_Data` holds a valid payload.
- `Out_Ready`, input, 1: decode consumes `Out_Data` this cycle.
- `Out_Data`, output, `DATA_W`: payload to decode.
- `Occupancy`, output, 2: number of held entries (0, 1 or 2).
- `Stall_Count`, output, `CNT_W`: saturating count of fetch-stall cycles.
- `Stall_Clr`, input, 1: synchronous clear of `Stall_Count`.

## Operation
- Storage:
  - `main` register drives `Out_Data`.
  - `skid` register holds the second entry.
- State register with three states: EMPTY, ONE, FULL.
- Derived signals:
  - `Out_Valid` = (state != EMPTY).
  - `In_Ready` = (state != FULL). Both are decoded from state flops only.
  - `Occupancy` = 0, 1 or 2 for EMPTY, ONE, FULL.
- Events in a cycle:
  - accept = `In_Valid` & `In_Ready`.
  - drain = `Out_Valid` & `Out_Ready`.
- Transitions (Flush=0):
  - EMPTY: accept → ONE, `main`←`In_Data`. Otherwise stay in EMPTY.
  - ONE, accept & drain → ONE, `main`←`In_Data`.
  - ONE, accept only → FULL, `skid`←`In_Data`.
  - ONE, drain only → EMPTY, `main`←BUBBLE.
  - ONE, neither → hold.
  - FULL: drain → ONE, `main`←`skid`, `skid`←BUBBLE. Otherwise hold. No accept is possible because `In_Ready`=0.
- Flush=1 has highest priority:
  - next state EMPTY; `main`,`skid`←BUBBLE.
  - any accept in the same cycle is discarded.
  - a drain in the same cycle still counts as consumed by decode.
- Invariant: `Out_Data`=BUBBLE whenever `Out_Valid`=0.
- Order is strictly FIFO; no payload is duplicated or dropped except by Flush.
- Stall counter:
  - increments on each cycle with `In_Valid`=1 and `In_Ready`=0.
  - saturates at 2^`CNT_W`−1.
  - `Stall_Clr` sets it to 0 and has priority over an increment in the same cycle.
  - Flush does not affect the counter.
- Async reset (`Reset`=0):
  - state EMPTY; `main`,`skid`=BUBBLE; `Stall_Count`=0.
  - outputs: `Out_Valid`=0, `In_Ready`=1, `Occupancy`=0, `Out_Data`=BUBBLE.
  - all inputs are ignored while `Reset`=0.
  - reset asserted mid-operation discards all held entries immediately, without waiting for a clock edge.

## Timing
- Latency: a payload accepted at edge N is on `Out_Data` with `Out_Valid`=1 after edge N, provided the stage was EMPTY, or ONE and draining.
- Throughput: 1 payload per cycle in steady state with `Out_Ready`=1.
- `In_Ready` deasserts after the edge at which the stage enters FULL. It reasserts after the first edge with a drain.
- Back-pressure needs 2 entries because `In_Ready` is registered. Fetch may see `In_Ready`=1 in the cycle decode stalls; the skid entry absorbs that payload.
- Flush at edge N: `Out_Valid`=0 and `Out_Data`=BUBBLE after edge N. A new payload can be accepted at edge N+1.
- No combinational path from any input to any output.

## Test plan
- Reset and bubble: hold `Reset`=0, then release.
  - Expect `Out_Valid`=0, `In_Ready`=1, `Out_Data`=BUBBLE (0x00), `Occupancy`=0, `Stall_Count`=0.
  - Assert Reset low mid-stream while FULL: outputs return to these values without a clock edge.
- Streaming: drive 0x11, 0x22, 0x33 on consecutive cycles with `Out_Ready`=1.
  - Expect each value on `Out_Data` one cycle after its accept edge, in order.
  - Expect `Occupancy`=1 throughout and `Stall_Count`=0.
- Back-pressure: stream 0xA1, 0xA2, 0xA3 with `Out_Ready`=0 from the second cycle.
  - Expect FULL holding 0xA1/0xA2 with `In_Ready`=0, and 0xA3 held at the input.
  - Expect `Stall_Count` to increment each stalled cycle.
  - Raise `Out_Ready`: expect 0xA1, 0xA2, 0xA3 in order with no loss or duplicate.
- Flush: in FULL state, assert Flush with `In_Valid`=1 and 0xF0 offered.
  - Next cycle: `Out_Valid`=0, `Out_Data`=0x00, `Occupancy`=0.
  - 0xF0 never appears on `Out_Data`.
- Counter saturation and clear: with `CNT_W`=2, hold a stall for 6 cycles.
  - Expect `Stall_Count`=3, held.
  - Assert `Stall_Clr` during a stall cycle: expect 0 on the next cycle.
- Parametrisation: rerun streaming and back-pressure with `DATA_W`=32 and `BUBBLE`=0x00000013, using random payloads checked against a reference FIFO model.
